// File: rtl/display_timing_gen_pkg.sv
// Shared video timing package.
// Holds the XGA and VGA raster constant sets, the coordinate width and the
// sync polarity encodings. Renderers import this package for their bounds so
// that every consumer agrees with the scan generator on screen geometry.
package display_timing_gen_pkg;

    // Coordinate width shared by every pixel consumer.
    localparam int unsigned CoordW    = 12;
    localparam int unsigned CoordMax  = 1 << CoordW;
    typedef logic [CoordW-1:0] coord_t;

    // Divider limits: 1..16 clk cycles per pixel fits a 4-bit counter.
    localparam int unsigned MaxClkDiv = 16;
    localparam int unsigned DivCntW   = 4;

    // Sync polarity: the value driven while the pulse is active.
    localparam logic SyncActiveLow  = 1'b0;
    localparam logic SyncActiveHigh = 1'b1;

    // XGA 1024x768@60 (65 MHz pixel clock).
    localparam int unsigned XgaHActive = 1024;
    localparam int unsigned XgaHFp     = 24;
    localparam int unsigned XgaHSync   = 136;
    localparam int unsigned XgaHBp     = 160;
    localparam int unsigned XgaHTotal  = XgaHActive + XgaHFp + XgaHSync + XgaHBp;
    localparam int unsigned XgaVActive = 768;
    localparam int unsigned XgaVFp     = 3;
    localparam int unsigned XgaVSync   = 6;
    localparam int unsigned XgaVBp     = 29;
    localparam int unsigned XgaVTotal  = XgaVActive + XgaVFp + XgaVSync + XgaVBp;

    // VGA 640x480@60 (25.175 MHz pixel clock).
    localparam int unsigned VgaHActive = 640;
    localparam int unsigned VgaHFp     = 16;
    localparam int unsigned VgaHSync   = 96;
    localparam int unsigned VgaHBp     = 48;
    localparam int unsigned VgaHTotal  = VgaHActive + VgaHFp + VgaHSync + VgaHBp;
    localparam int unsigned VgaVActive = 480;
    localparam int unsigned VgaVFp     = 10;
    localparam int unsigned VgaVSync   = 2;
    localparam int unsigned VgaVBp     = 33;
    localparam int unsigned VgaVTotal  = VgaVActive + VgaVFp + VgaVSync + VgaVBp;

    // Inclusive window test; an inclusive upper bound keeps every limit
    // representable in CoordW bits even when a total reaches CoordMax.
    function automatic logic in_window(coord_t v, coord_t first, coord_t last);
        return (v >= first) && (v <= last);
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Pixel tick divider.
// Produces a one-clk pixel enable every CLK_DIV clock cycles so the scan
// generator can run from a system clock faster than the pixel rate.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   pix_en_o : high on the clk edges where the pixel counters advance
module pix_tick_div
    import display_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_en_o
);

    localparam logic [DivCntW-1:0] LastCnt = DivCntW'(CLK_DIV - 1);

    logic [DivCntW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == LastCnt) ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // With CLK_DIV=1 LastCnt is 0, so the enable is constantly high.
    assign pix_en_o = (div_cnt_q == LastCnt);

endmodule

// File: rtl/display_timing_gen.sv
// Raster scan timing generator.
// Produces the pixel coordinates, sync pulses and active-video flag sampled by
// every pixel consumer in the video path. Defaults to XGA 1024x768@60.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   pix_en       : pixel tick; counters advance on edges where it is high
//   pixel_column : horizontal count, 0..H_TOTAL-1 (blanking included)
//   pixel_row    : vertical count, 0..V_TOTAL-1 (blanking included)
//   video_on     : inside the visible area
//   horiz_sync   : horizontal sync, active level SYNC_POL
//   vert_sync    : vertical sync, active level SYNC_POL
//   line_start   : one-clk pulse after column 0 is loaded
//   frame_start  : one-clk pulse after (0,0) is loaded
module display_timing_gen
    import display_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = XgaHActive,
    parameter int unsigned H_FP     = XgaHFp,
    parameter int unsigned H_SYNC   = XgaHSync,
    parameter int unsigned H_BP     = XgaHBp,
    parameter int unsigned V_ACTIVE = XgaVActive,
    parameter int unsigned V_FP     = XgaVFp,
    parameter int unsigned V_SYNC   = XgaVSync,
    parameter int unsigned V_BP     = XgaVBp,
    parameter logic        SYNC_POL = SyncActiveLow,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              pix_en,
    output logic [CoordW-1:0] pixel_column,
    output logic [CoordW-1:0] pixel_row,
    output logic              video_on,
    output logic              horiz_sync,
    output logic              vert_sync,
    output logic              line_start,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (CLK_DIV < 1 || CLK_DIV > MaxClkDiv) begin : g_bad_clk_div
        $error("display_timing_gen: CLK_DIV must be within 1..16");
    end
    if (H_TOTAL > CoordMax || V_TOTAL > CoordMax) begin : g_bad_total
        $error("display_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
    end
    if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_active
        $error("display_timing_gen: active area must be non-empty");
    end

    // All bounds are inclusive 12-bit values.
    localparam coord_t HLast      = coord_t'(H_TOTAL - 1);
    localparam coord_t VLast      = coord_t'(V_TOTAL - 1);
    localparam coord_t HActLast   = coord_t'(H_ACTIVE - 1);
    localparam coord_t VActLast   = coord_t'(V_ACTIVE - 1);
    localparam coord_t HSyncFirst = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HSyncLast  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VSyncFirst = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VSyncLast  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t col_q, col_d;
    coord_t row_q, row_d;
    logic   video_on_q, video_on_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    pix_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_div (
        .clk_i    (clk),
        .rst_ni   (reset),
        .pix_en_o (pix_en)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_en) begin
            if (col_q == HLast) begin
                col_d = '0;
                row_d = (row_q == VLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // Decoded from the next coordinates so they line up with the
        // counter registers that load in the same edge.
        video_on_d    = (col_d <= HActLast) && (row_d <= VActLast);
        hsync_d       = in_window(col_d, HSyncFirst, HSyncLast) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = in_window(row_d, VSyncFirst, VSyncLast) ? SYNC_POL : ~SYNC_POL;

        // Pulses only on a pixel tick, so they stay one clk wide for any CLK_DIV.
        line_start_d  = pix_en && (col_d == '0);
        frame_start_d = line_start_d && (row_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q         <= HLast;
            row_q         <= VLast;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            // Counters and level decodes hold between pixel ticks.
            if (pix_en) begin
                col_q      <= col_d;
                row_q      <= row_d;
                video_on_q <= video_on_d;
                hsync_q    <= hsync_d;
                vsync_q    <= vsync_d;
            end
        end
    end

    assign pixel_column = col_q;
    assign pixel_row    = row_q;
    assign video_on     = video_on_q;
    assign horiz_sync   = hsync_q;
    assign vert_sync    = vsync_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: an XGA instance checked against hand-computed
// vectors (including a mid-line asynchronous reset), plus two small-raster
// instances (CLK_DIV=1 active-high sync, CLK_DIV=4 active-low sync) checked
// every clk against a linear-count reference model.
module tb_display_timing_gen;

    typedef struct packed {
        logic        pe;
        logic [11:0] col;
        logic [11:0] row;
        logic        vo;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int   k;
        obs_t exp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a  = 1'b0;
    logic rst_bc = 1'b0;

    int errors = 0;
    int checks = 0;

    // Edge counts since reset release, one per reset domain.
    int k_a  = 0;
    int k_bc = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    // ---------------- DUT A: XGA defaults, CLK_DIV=1 ----------------
    logic        pe_a, vo_a, hs_a, vs_a, ls_a, fs_a;
    logic [11:0] col_a, row_a;
    obs_t        obs_a;

    display_timing_gen u_dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .pix_en       (pe_a),
        .pixel_column (col_a),
        .pixel_row    (row_a),
        .video_on     (vo_a),
        .horiz_sync   (hs_a),
        .vert_sync    (vs_a),
        .line_start   (ls_a),
        .frame_start  (fs_a)
    );
    assign obs_a = {pe_a, col_a, row_a, vo_a, hs_a, vs_a, ls_a, fs_a};

    // ---------------- DUT B: small raster, active-high sync ----------------
    logic        pe_b, vo_b, hs_b, vs_b, ls_b, fs_b;
    logic [11:0] col_b, row_b;
    obs_t        obs_b;

    display_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1), .CLK_DIV (1)
    ) u_dut_b (
        .clk          (clk),
        .reset        (rst_bc),
        .pix_en       (pe_b),
        .pixel_column (col_b),
        .pixel_row    (row_b),
        .video_on     (vo_b),
        .horiz_sync   (hs_b),
        .vert_sync    (vs_b),
        .line_start   (ls_b),
        .frame_start  (fs_b)
    );
    assign obs_b = {pe_b, col_b, row_b, vo_b, hs_b, vs_b, ls_b, fs_b};

    // ---------------- DUT C: small raster, CLK_DIV=4 ----------------
    logic        pe_c, vo_c, hs_c, vs_c, ls_c, fs_c;
    logic [11:0] col_c, row_c;
    obs_t        obs_c;

    display_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b0), .CLK_DIV (4)
    ) u_dut_c (
        .clk          (clk),
        .reset        (rst_bc),
        .pix_en       (pe_c),
        .pixel_column (col_c),
        .pixel_row    (row_c),
        .video_on     (vo_c),
        .horiz_sync   (hs_c),
        .vert_sync    (vs_c),
        .line_start   (ls_c),
        .frame_start  (fs_c)
    );
    assign obs_c = {pe_c, col_c, row_c, vo_c, hs_c, vs_c, ls_c, fs_c};

    // ---------------- helpers ----------------
    function automatic obs_t mk(logic pe, int col, int row, logic vo, logic hs, logic vs,
                                logic ls, logic fs);
        obs_t o;
        o.pe  = pe;
        o.col = 12'(col);
        o.row = 12'(row);
        o.vo  = vo;
        o.hs  = hs;
        o.vs  = vs;
        o.ls  = ls;
        o.fs  = fs;
        return o;
    endfunction

    // Expected outputs after k clk edges since release, derived from the
    // total pixel count rather than from a stepped counter.
    function automatic obs_t model(int k, int d, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, logic pol);
        obs_t o;
        int   ht;
        int   vt;
        int   ticks;
        int   p;
        int   c;
        int   r;
        logic just;
        ht    = ha + hf + hsw + hb;
        vt    = va + vf + vsw + vb;
        ticks = k / d;
        just  = (k > 0) && ((k % d) == 0);
        o.pe  = ((k % d) == (d - 1));
        if (ticks == 0) begin
            o.col = 12'(ht - 1);
            o.row = 12'(vt - 1);
            o.vo  = 1'b0;
            o.hs  = ~pol;
            o.vs  = ~pol;
            o.ls  = 1'b0;
            o.fs  = 1'b0;
        end else begin
            p     = ticks - 1;
            c     = p % ht;
            r     = (p / ht) % vt;
            o.col = 12'(c);
            o.row = 12'(r);
            o.vo  = (c < ha) && (r < va);
            o.hs  = (c >= ha + hf && c < ha + hf + hsw) ? pol : ~pol;
            o.vs  = (r >= va + vf && r < va + vf + vsw) ? pol : ~pol;
            o.ls  = just && (c == 0);
            o.fs  = just && (c == 0) && (r == 0);
        end
        return o;
    endfunction

    // Hand-computed XGA vectors, keyed by edges since release.
    function automatic bit xga_dir(int k, output obs_t o);
        xga_dir = 1'b1;
        case (k)
            1:       o = mk(1, 0,    0, 1, 1, 1, 1, 1);
            2:       o = mk(1, 1,    0, 1, 1, 1, 0, 0);
            1024:    o = mk(1, 1023, 0, 1, 1, 1, 0, 0);
            1025:    o = mk(1, 1024, 0, 0, 1, 1, 0, 0);
            1048:    o = mk(1, 1047, 0, 0, 1, 1, 0, 0);
            1049:    o = mk(1, 1048, 0, 0, 0, 1, 0, 0);
            1184:    o = mk(1, 1183, 0, 0, 0, 1, 0, 0);
            1185:    o = mk(1, 1184, 0, 0, 1, 1, 0, 0);
            1344:    o = mk(1, 1343, 0, 0, 1, 1, 0, 0);
            1345:    o = mk(1, 0,    1, 1, 1, 1, 1, 0);
            1346:    o = mk(1, 1,    1, 1, 1, 1, 0, 0);
            2444:    o = mk(1, 1099, 1, 0, 0, 1, 0, 0);
            default: begin
                o       = '0;
                xga_dir = 1'b0;
            end
        endcase
    endfunction

    task automatic cmp(input string name, input int k, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual pe=%b col=%0d row=%0d vo=%b hs=%b vs=%b ls=%b fs=%b required pe=%b col=%0d row=%0d vo=%b hs=%b vs=%b ls=%b fs=%b",
                     name, k, act.pe, act.col, act.row, act.vo, act.hs, act.vs, act.ls,
                     act.fs, exp.pe, exp.col, exp.row, exp.vo, exp.hs, exp.vs, exp.ls, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- expectation producers ----------------
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            if (!rst_a) begin
                k_a = 0;
            end else begin
                k_a++;
                if (xga_dir(k_a, e)) q_a.push_back('{k_a, e});
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_bc) begin
                k_bc = 0;
            end else begin
                k_bc++;
                q_b.push_back('{k_bc, model(k_bc, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1)});
                q_c.push_back('{k_bc, model(k_bc, 4, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0)});
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        int   cyc = 0;
        int   hs_low = 0;
        bit   hs_done = 1'b0;
        int   last_fs_b = -1;
        int   last_fs_c = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp("xga_vector", e.k, obs_a, e.exp);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                cmp("small_div1", e.k, obs_b, e.exp);
            end
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                cmp("small_div4", e.k, obs_c, e.exp);
            end
            // hsync width over the first line of the XGA scan.
            if (!hs_done && rst_a && k_a >= 1 && k_a <= 1344 && !obs_a.hs) hs_low++;
            if (!hs_done && rst_a && k_a == 1345) begin
                check_int("xga_hsync_width", hs_low, 136);
                hs_done = 1'b1;
            end
            if (rst_bc && obs_b.fs) begin
                if (last_fs_b >= 0) check_int("small_div1_frame_period", cyc - last_fs_b, 98);
                last_fs_b = cyc;
            end
            if (rst_bc && obs_c.fs) begin
                if (last_fs_c >= 0) check_int("small_div4_frame_period", cyc - last_fs_c, 392);
                last_fs_c = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset-state expectations, consumed at the first falling edge.
        q_a.push_back('{0, mk(1, 1343, 805, 0, 1, 1, 0, 0)});
        q_b.push_back('{0, model(0, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1)});
        q_c.push_back('{0, model(0, 4, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0)});

        repeat (3) @(negedge clk);
        #1;
        rst_a  = 1'b1;
        rst_bc = 1'b1;

        // Run into row 1 with hsync active, then reset asynchronously mid-cycle.
        repeat (2444) @(posedge clk);
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        cmp("xga_async_reset", k_a, obs_a, mk(1, 1343, 805, 0, 1, 1, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_a = 1'b1;

        // Restart from (0,0): the directed vectors for the first line apply again.
        repeat (1400) @(posedge clk);
        @(negedge clk);
        #1;
        check_int("queues_drained", q_a.size() + q_b.size() + q_c.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Generates the raster scan that every pixel consumer in the video path samples: `pixel_column`, `pixel_row`, sync pulses and `video_on`.
- It is the producer end of the pixel-coordinate interface used by the icon/sprite renderers and the colorizer.
- Default timing is XGA 1024x768@60. Bot coordinates map to screen as LocX*8 and LocY*6 over this area.
- The optional clock divider lets the block run from a faster system clock.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels); H_TOTAL = sum = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
- SYNC_POL, 0, active sync level (0 = active-low)
- CLK_DIV, 1, clk cycles per pixel (1..16)

Ports:
- clk  in  1  system/pixel clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pix_en  out  1  pixel tick; the counters advance on clk edges where pix_en=1
- pixel_column  out  12  current horizontal count, 0..H_TOTAL-1 (includes blanking)
- pixel_row  out  12  current vertical count, 0..V_TOTAL-1 (includes blanking)
- video_on  out  1  1 when pixel_column<H_ACTIVE and pixel_row<V_ACTIVE
- horiz_sync  out  1  horizontal sync, level per SYNC_POL
- vert_sync  out  1  vertical sync, level per SYNC_POL
- line_start  out  1  one-clk pulse when pixel_column enters 0
- frame_start  out  1  one-clk pulse when (row,col) enters (0,0)

Behaviour:
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps. pix_en = (div_cnt==CLK_DIV-1), decoded combinationally from the register.
  - CLK_DIV=1 gives pix_en constant 1 out of reset.
- Counters:
  - pixel_column and pixel_row are the counter registers themselves; there is no extra pipeline.
  - On a pix_en edge: col = (col==H_TOTAL-1) ? 0 : col+1.
  - Row increments only when col wraps; row wraps V_TOTAL-1 -> 0 together with col.
  - Outputs hold between pix_en ticks.
- Decodes:
  - video_on, horiz_sync and vert_sync are registered. They are computed from the next counter values in the same edge, so they align exactly with the coordinates they describe.
  - hsync is active for H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC (default 1048..1183).
  - vsync is active for V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC (default 771..776), for entire lines.
- Pulses:
  - line_start and frame_start are high for the single clk cycle following the edge that loaded col=0 (respectively row=0,col=0).
  - They are low otherwise, even when CLK_DIV>1.
- Reset (asynchronous, immediate):
  - col=H_TOTAL-1, row=V_TOTAL-1, div_cnt=0.
  - video_on=0, horiz_sync=vert_sync=inactive (~SYNC_POL), line_start=frame_start=0.
  - pix_en follows div_cnt=0.
  - The first pix_en edge after release loads (0,0) with video_on=1, line_start=1, frame_start=1.
- Mid-frame reset: all state returns to reset values regardless of position; no partial sync pulse is extended.
- Widths:
  - All comparisons are done on 12-bit unsigned values.
  - H_TOTAL and V_TOTAL must be <= 4096.
  - Illegal parameters (CLK_DIV=0, totals >4096) are rejected by elaboration-time checks.

Decomposition:
- Shared video package:
  - XGA and VGA timing constant sets (active, front porch, sync, back porch, totals).
  - The coordinate width (12).
  - The sync-polarity constant.
  - Renderers reuse the same constants for bounds.
- One sub-module: pix_tick_div (parameterised divider producing pix_en).
- Counters and decode stay in the top module.

Test Plan:
1. Reset release, defaults, CLK_DIV=1 -> first edge: col=0, row=0, video_on=1, line_start=1, frame_start=1, both syncs high.
2. Scan row 0 -> video_on falls when col=1024; horiz_sync low for col 1048..1183 (136 clks); col 1343->0, row 0->1, line_start one cycle.
3. Full frame -> vert_sync low for rows 771..776 exactly (6*1344 clks); row 805/col 1343 -> (0,0) with frame_start. frame_start period is exactly 1,083,264 clks.
4. CLK_DIV=4 -> pix_en high 1 in 4 clks; coordinates step only on pix_en; frame_start remains 1 clk wide; period 4,333,056 clks.
5. Assert reset asynchronously at col=500,row=300 between edges -> outputs take reset values before the next clk edge; after release, the scan restarts at (0,0).
6. Small params (H 8/2/2/2, V 4/1/1/1, SYNC_POL=1) -> sync active-high at col 10..11 and row 5, wrap at 13/6; checked exhaustively against a reference counter model.
